// File: rtl/cpu_mul_pkg.sv
// Shared constants and the writeback slot layout for the pipelined multiplier scoreboard.
// mul_wb_t matches the record consumed by the hazard detection unit.
package cpu_mul_pkg;
    localparam int NUM_REGS    = 32;
    localparam int REG_W       = $clog2(NUM_REGS);
    localparam int MUL_LAT     = 5;
    localparam int COMMIT_DIST = 3;

    typedef struct packed {
        logic             write_back;
        logic [REG_W-1:0] rd_id;
    } mul_wb_t;
endpackage

// File: rtl/cpu_mul_slot_pipe.sv
// Fixed-depth shift register of in-flight multiply slots; never stalls, index 0 is youngest.
module cpu_mul_slot_pipe
    import cpu_mul_pkg::*;
#(
    parameter int DEPTH = MUL_LAT
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  mul_wb_t             entry_i,
    output mul_wb_t [DEPTH-1:0] stages_o
);
    mul_wb_t [DEPTH-1:0] stages_q;
    mul_wb_t [DEPTH-1:0] stages_d;

    always_comb begin
        stages_d    = stages_q;
        stages_d[0] = entry_i;
        for (int i = 1; i < DEPTH; i++) begin
            stages_d[i] = stages_q[i-1];
        end
    end

    // Reset discards every in-flight multiply so no writeback can leak out afterwards.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign stages_o = stages_q;
endmodule

// File: rtl/cpu_mul_scoreboard.sv
// Issue controller and writeback scheduler for the fixed-latency multiplier: busy tracking,
// RAW/WAW/write-port hazard stall, accept logic and the multiplier writeback port.
module cpu_mul_scoreboard
    import cpu_mul_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         decode_rd,
    input  logic [REG_W-1:0]         decode_ra,
    input  logic [REG_W-1:0]         decode_rb,
    input  logic                     ra_use,
    input  logic                     rb_use,
    input  logic                     rd_use,
    input  logic                     ext_stall,
    input  logic                     flush,
    output logic                     stall,
    output logic                     issue_accept,
    output logic [MUL_LAT-1:0]       stage_valid,
    output logic [MUL_LAT*REG_W-1:0] stage_rd,
    output logic                     mul_wb_valid,
    output logic [REG_W-1:0]         mul_wb_rd,
    output logic [NUM_REGS-1:0]      busy_vec
);
    localparam int PORT_STAGE = MUL_LAT - 1 - COMMIT_DIST;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    mul_wb_t               entry;
    mul_wb_t [MUL_LAT-1:0] stages;
    logic                  raw;
    logic                  waw;
    logic                  port;

    assign raw  = (ra_use & busy_q[decode_ra]) | (rb_use & busy_q[decode_rb]);
    assign waw  = rd_use & busy_q[decode_rd];
    // A non-mul writer would hit the RF in the same cycle this stage's multiply retires.
    assign port = rd_use & ~issue_valid & stages[PORT_STAGE].write_back;

    assign stall        = raw | waw | port;
    assign issue_accept = issue_valid & ~stall & ~ext_stall & ~flush & ~reset;

    assign entry.write_back = issue_accept;
    assign entry.rd_id      = decode_rd;

    cpu_mul_slot_pipe #(
        .DEPTH (MUL_LAT)
    ) u_slot_pipe (
        .clk_i    (clk),
        .reset_i  (reset),
        .entry_i  (entry),
        .stages_o (stages)
    );

    always_comb begin
        stage_valid = '0;
        stage_rd    = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            stage_valid[i]              = stages[i].write_back;
            stage_rd[i*REG_W +: REG_W]  = stages[i].rd_id;
        end
    end

    assign mul_wb_valid = stages[MUL_LAT-1].write_back;
    assign mul_wb_rd    = stages[MUL_LAT-1].rd_id;

    // Retiring register stays busy this cycle; a same-cycle re-issue must win over the clear.
    always_comb begin
        busy_d = busy_q;
        if (mul_wb_valid) begin
            busy_d[mul_wb_rd] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[decode_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
endmodule

// File: tb/tb_cpu_mul_scoreboard.sv
// Directed bench for cpu_mul_scoreboard: a cycle-by-cycle vector table plus hand sequences
// for flush/ext_stall blocking, source-B RAW and reset in the middle of a multiply.
module tb_cpu_mul_scoreboard;
    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  decode_rd;
    logic [4:0]  decode_ra;
    logic [4:0]  decode_rb;
    logic        ra_use;
    logic        rb_use;
    logic        rd_use;
    logic        ext_stall;
    logic        flush;
    logic        stall;
    logic        issue_accept;
    logic [4:0]  stage_valid;
    logic [24:0] stage_rd;
    logic        mul_wb_valid;
    logic [4:0]  mul_wb_rd;
    logic [31:0] busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mul_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .decode_rd    (decode_rd),
        .decode_ra    (decode_ra),
        .decode_rb    (decode_rb),
        .ra_use       (ra_use),
        .rb_use       (rb_use),
        .rd_use       (rd_use),
        .ext_stall    (ext_stall),
        .flush        (flush),
        .stall        (stall),
        .issue_accept (issue_accept),
        .stage_valid  (stage_valid),
        .stage_rd     (stage_rd),
        .mul_wb_valid (mul_wb_valid),
        .mul_wb_rd    (mul_wb_rd),
        .busy_vec     (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic        rau;
        logic        rdu;
        logic        e_stall;
        logic        e_acc;
        logic        e_wbv;
        logic [4:0]  e_wbrd;
        logic [31:0] e_busy;
        logic [4:0]  e_sv;
    } vec_t;

    function automatic vec_t mk(logic rst, logic iv, logic [4:0] rd, logic [4:0] ra,
                                logic rau, logic rdu, logic e_stall, logic e_acc,
                                logic e_wbv, logic [4:0] e_wbrd, logic [31:0] e_busy,
                                logic [4:0] e_sv);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rd = rd; v.ra = ra; v.rau = rau; v.rdu = rdu;
        v.e_stall = e_stall; v.e_acc = e_acc; v.e_wbv = e_wbv; v.e_wbrd = e_wbrd;
        v.e_busy = e_busy; v.e_sv = e_sv;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic rau,
                         input logic rbu, input logic rdu, input logic ext, input logic fl);
        reset = rst; issue_valid = iv; decode_rd = rd; decode_ra = ra; decode_rb = rb;
        ra_use = rau; rb_use = rbu; rd_use = rdu; ext_stall = ext; flush = fl;
    endtask

    vec_t tbl[20];

    initial begin
        // Rows: rst iv rd ra rau rdu | stall acc wbv wbrd busy stage_valid
        tbl[0]  = mk(1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 32'h0,   5'b00000);
        tbl[1]  = mk(1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 32'h0,   5'b00000);
        tbl[2]  = mk(0, 1, 7, 0, 0, 1,  0, 1, 0, 0, 32'h0,   5'b00000);
        tbl[3]  = mk(0, 1, 8, 7, 1, 1,  1, 0, 0, 0, 32'h80,  5'b00001);
        tbl[4]  = mk(0, 1, 8, 7, 1, 1,  1, 0, 0, 0, 32'h80,  5'b00010);
        tbl[5]  = mk(0, 1, 8, 7, 1, 1,  1, 0, 0, 0, 32'h80,  5'b00100);
        tbl[6]  = mk(0, 1, 8, 7, 1, 1,  1, 0, 0, 0, 32'h80,  5'b01000);
        tbl[7]  = mk(0, 1, 8, 7, 1, 1,  1, 0, 1, 7, 32'h80,  5'b10000);
        tbl[8]  = mk(0, 1, 8, 7, 1, 1,  0, 1, 0, 0, 32'h0,   5'b00000);
        tbl[9]  = mk(0, 1, 3, 0, 0, 1,  0, 1, 0, 0, 32'h100, 5'b00001);
        tbl[10] = mk(0, 0, 9, 0, 0, 1,  1, 0, 0, 0, 32'h108, 5'b00011);
        tbl[11] = mk(0, 0, 9, 0, 0, 1,  1, 0, 0, 0, 32'h108, 5'b00110);
        tbl[12] = mk(0, 0, 9, 0, 0, 1,  0, 0, 0, 0, 32'h108, 5'b01100);
        tbl[13] = mk(0, 1, 4, 0, 0, 1,  0, 1, 1, 8, 32'h108, 5'b11000);
        tbl[14] = mk(0, 1, 4, 0, 0, 1,  1, 0, 1, 3, 32'h18,  5'b10001);
        tbl[15] = mk(0, 1, 4, 0, 0, 1,  1, 0, 0, 0, 32'h10,  5'b00010);
        tbl[16] = mk(0, 1, 4, 0, 0, 1,  1, 0, 0, 0, 32'h10,  5'b00100);
        tbl[17] = mk(0, 1, 4, 0, 0, 1,  1, 0, 0, 0, 32'h10,  5'b01000);
        tbl[18] = mk(0, 1, 4, 0, 0, 1,  1, 0, 1, 4, 32'h10,  5'b10000);
        tbl[19] = mk(0, 1, 4, 0, 0, 1,  0, 1, 0, 0, 32'h0,   5'b00000);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].iv, tbl[i].rd, tbl[i].ra, 5'd0, tbl[i].rau, 1'b0,
                  tbl[i].rdu, 1'b0, 1'b0);
            #1;
            chk("stall",        i, 32'(stall),        32'(tbl[i].e_stall));
            chk("issue_accept", i, 32'(issue_accept), 32'(tbl[i].e_acc));
            chk("mul_wb_valid", i, 32'(mul_wb_valid), 32'(tbl[i].e_wbv));
            chk("busy_vec",     i, busy_vec,          tbl[i].e_busy);
            chk("stage_valid",  i, 32'(stage_valid),  32'(tbl[i].e_sv));
            if (tbl[i].e_wbv) chk("mul_wb_rd", i, 32'(mul_wb_rd), 32'(tbl[i].e_wbrd));
            if (tbl[i].rst && i > 0) chk("stage_rd_reset", i, 32'(stage_rd), 32'h0);
        end

        // Clear the multiply left in flight by the last table row.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // flush blocks entry
        @(negedge clk);
        drive(0, 1, 5, 0, 0, 0, 0, 1, 0, 1);
        #1;
        chk("flush_accept", 100, 32'(issue_accept), 32'h0);
        chk("flush_stall",  100, 32'(stall),        32'h0);
        // ext_stall blocks entry
        @(negedge clk);
        drive(0, 1, 5, 0, 0, 0, 0, 1, 1, 0);
        #1;
        chk("ext_accept", 101, 32'(issue_accept), 32'h0);
        chk("flush_busy", 101, busy_vec,          32'h0);
        chk("flush_sv",   101, 32'(stage_valid),  32'h0);
        // real issue of rd=5, cycle 0
        @(negedge clk);
        drive(0, 1, 5, 0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("ext_busy",    102, busy_vec,           32'h0);
        chk("issue5_acc",  102, 32'(issue_accept),  32'h1);
        // cycle 1: non-mul reading rb=5 must stall on RAW
        @(negedge clk);
        drive(0, 0, 0, 0, 5, 0, 1, 0, 0, 0);
        #1;
        chk("rb_raw_stall", 103, 32'(stall),          32'h1);
        chk("issue5_busy",  103, busy_vec,            32'h20);
        chk("issue5_rd0",   103, 32'(stage_rd[4:0]),  32'h5);
        // cycle 2: reset mid-flight
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_sv", 104, 32'(stage_valid), 32'h2);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("post_reset_wbv",  110 + c, 32'(mul_wb_valid), 32'h0);
            chk("post_reset_busy", 110 + c, busy_vec,          32'h0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
